// File: rtl/racer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : racer_pkg
// Purpose : Shared race-state encoding and lap-time widths for the overlays.
// Rev     : 1.0  initial release
// ============================================================================
package racer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACING    = 2'd2,
    FINISHED  = 2'd3
  } race_state_t;

  localparam int                    LAP_TIME_W       = 16;
  localparam logic [LAP_TIME_W-1:0] LAP_TIME_MAX     = 16'hFFFF;
  localparam int                    TICKS_PER_CS_DEF = 650000;

endpackage
`default_nettype wire

// File: rtl/lap_cs_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : lap_cs_tick_gen
// Purpose : Centisecond prescaler with enable and synchronous clear.
// Rev     : 1.0  initial release
// ============================================================================
module lap_cs_tick_gen
  import racer_pkg::*;
#(
  parameter int TICKS_PER_CS = TICKS_PER_CS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic cs_tick
);

  localparam int               CNT_W  = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(TICKS_PER_CS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap  = (r_cnt == c_last);
  assign cs_tick = en & w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || (en && w_wrap)) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lap_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lap_timer_ctrl
// Purpose : Race sequencer and lap timer; best-lap tracking is built only when
//           LAP_TIMER_BEST_LAP_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module lap_timer_ctrl
  import racer_pkg::*;
#(
  parameter int TICKS_PER_CS = TICKS_PER_CS_DEF,
  parameter int COUNTDOWN_CS = 300,
  parameter int NUM_LAPS     = 3
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  checkpoint,
  input  logic                  finish_line,
  output logic [1:0]            race_state,
  output logic [1:0]            countdown_digit,
  output logic [LAP_TIME_W-1:0] cur_lap_time,
  output logic [LAP_TIME_W-1:0] last_lap_time,
  output logic [LAP_TIME_W-1:0] best_lap_time,
  output logic [3:0]            lap_count,
  output logic                  lap_done
);

  localparam int              CD_W      = $clog2(COUNTDOWN_CS + 1);
  localparam logic [CD_W-1:0] c_cd_last = CD_W'(COUNTDOWN_CS - 1);
  // Digit drops below 3 at ceil(C/3) and below 2 at ceil(2C/3).
  localparam logic [CD_W-1:0] c_cd_thr3 = CD_W'((COUNTDOWN_CS + 2) / 3);
  localparam logic [CD_W-1:0] c_cd_thr2 = CD_W'((2 * COUNTDOWN_CS + 2) / 3);
  localparam logic [3:0]      c_num_laps = 4'(NUM_LAPS);

  race_state_t           r_state, w_state_next;
  logic [CD_W-1:0]       r_cd_cnt;
  logic                  r_fin_q, r_cp_q, r_armed, r_lap_done;
  logic [LAP_TIME_W-1:0] r_cur, r_last;
  logic [3:0]            r_lap_count;
  logic [1:0]            w_digit;
  logic                  w_cs_tick, w_fin_rise, w_cp_rise, w_valid_lap, w_start_race;

  assign w_fin_rise   = finish_line & ~r_fin_q;
  assign w_cp_rise    = checkpoint & ~r_cp_q;
  assign w_valid_lap  = (r_state == RACING) && w_fin_rise && r_armed;
  assign w_start_race = start && ((r_state == IDLE) || (r_state == FINISHED));

  lap_cs_tick_gen #(
    .TICKS_PER_CS(TICKS_PER_CS)
  ) u_tick (
    .clk    (pclk),
    .rst    (rst),
    .en     ((r_state == COUNTDOWN) || (r_state == RACING)),
    .clr    (w_state_next != r_state),
    .cs_tick(w_cs_tick)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_digit      = 2'd0;
    case (r_state)
      IDLE:      if (start) w_state_next = COUNTDOWN;
      COUNTDOWN: begin
        if (w_cs_tick && (r_cd_cnt == c_cd_last)) w_state_next = RACING;
        if (r_cd_cnt < c_cd_thr3)      w_digit = 2'd3;
        else if (r_cd_cnt < c_cd_thr2) w_digit = 2'd2;
        else                           w_digit = 2'd1;
      end
      RACING:    if (w_valid_lap && ((r_lap_count + 4'd1) == c_num_laps)) w_state_next = FINISHED;
      FINISHED:  if (start) w_state_next = COUNTDOWN;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_fin_q     <= 1'b0;
      r_cp_q      <= 1'b0;
      r_armed     <= 1'b0;
      r_lap_done  <= 1'b0;
      r_cd_cnt    <= '0;
      r_cur       <= '0;
      r_last      <= '0;
      r_lap_count <= '0;
    end else begin
      r_fin_q    <= finish_line;
      r_cp_q     <= checkpoint;
      r_lap_done <= 1'b0;
      if (w_start_race) begin
        r_cd_cnt    <= '0;
        r_cur       <= '0;
        r_last      <= '0;
        r_lap_count <= '0;
        r_armed     <= 1'b0;
      end else if (r_state == COUNTDOWN) begin
        if (w_cs_tick) begin
          if (r_cd_cnt == c_cd_last) begin
            r_cd_cnt <= '0;
            r_cur    <= '0;
          end else begin
            r_cd_cnt <= r_cd_cnt + CD_W'(1);
          end
        end
      end else if (r_state == RACING) begin
        // A lap restart wins over a coincident tick.
        if (w_valid_lap) begin
          r_last      <= r_cur;
          r_cur       <= '0;
          r_lap_count <= r_lap_count + 4'd1;
          r_lap_done  <= 1'b1;
        end else if (w_cs_tick && (r_cur != LAP_TIME_MAX)) begin
          r_cur <= r_cur + LAP_TIME_W'(1);
        end
        if (w_cp_rise)        r_armed <= 1'b1;
        else if (w_valid_lap) r_armed <= 1'b0;
      end
    end
  end

`ifdef LAP_TIMER_BEST_LAP_EN
  logic [LAP_TIME_W-1:0] r_best;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_best <= '0;
    end else if (w_start_race) begin
      r_best <= '0;
    end else if (w_valid_lap && ((r_lap_count == 4'd0) || (r_cur < r_best))) begin
      r_best <= r_cur;
    end
  end

  assign best_lap_time = r_best;
`else
  assign best_lap_time = '0;
`endif

  assign race_state      = r_state;
  assign countdown_digit = w_digit;
  assign cur_lap_time    = r_cur;
  assign last_lap_time   = r_last;
  assign lap_count       = r_lap_count;
  assign lap_done        = r_lap_done;

endmodule
`default_nettype wire

// File: tb/tb_lap_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lap_timer_ctrl
// Purpose : Self-checking bench: directed vector table, random run against a
//           behavioural model, and a saturation run on a fast-tick instance.
// Rev     : 1.0  initial release
// ============================================================================
module tb_lap_timer_ctrl;

  localparam int T  = 4;
  localparam int C  = 6;
  localparam int NL = 2;
`ifdef LAP_TIMER_BEST_LAP_EN
  localparam int B1 = 37;
  localparam int B2 = 25;
  localparam int BS = 65535;
`else
  localparam int B1 = 0;
  localparam int B2 = 0;
  localparam int BS = 0;
`endif

  logic        pclk, rst, start, checkpoint, finish_line;
  logic [1:0]  race_state, countdown_digit;
  logic [15:0] cur_lap_time, last_lap_time, best_lap_time;
  logic [3:0]  lap_count;
  logic        lap_done;

  logic        s_start, s_cp, s_fin;
  logic [1:0]  s_state, s_digit;
  logic [15:0] s_cur, s_last, s_best;
  logic [3:0]  s_laps;
  logic        s_done;

  lap_timer_ctrl #(.TICKS_PER_CS(T), .COUNTDOWN_CS(C), .NUM_LAPS(NL)) dut (
    .pclk(pclk), .rst(rst), .start(start), .checkpoint(checkpoint),
    .finish_line(finish_line), .race_state(race_state),
    .countdown_digit(countdown_digit), .cur_lap_time(cur_lap_time),
    .last_lap_time(last_lap_time), .best_lap_time(best_lap_time),
    .lap_count(lap_count), .lap_done(lap_done)
  );

  lap_timer_ctrl #(.TICKS_PER_CS(1), .COUNTDOWN_CS(C), .NUM_LAPS(NL)) u_sat (
    .pclk(pclk), .rst(rst), .start(s_start), .checkpoint(s_cp),
    .finish_line(s_fin), .race_state(s_state), .countdown_digit(s_digit),
    .cur_lap_time(s_cur), .last_lap_time(s_last), .best_lap_time(s_best),
    .lap_count(s_laps), .lap_done(s_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic st, cp, fin;
    int   n;
    int   e_state, e_digit, e_cur, e_last, e_laps, e_done, e_best;
  } vec_t;

  vec_t tbl [0:22];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic cp, input logic fin, input int n,
                              input int es, input int ed, input int ec, input int el,
                              input int ela, input int edn, input int eb);
    vec_t v;
    v.st = st; v.cp = cp; v.fin = fin; v.n = n;
    v.e_state = es; v.e_digit = ed; v.e_cur = ec; v.e_last = el;
    v.e_laps = ela; v.e_done = edn; v.e_best = eb;
    return v;
  endfunction

  task automatic drive_cycle(input logic s, input logic c, input logic f);
    start = s; checkpoint = c; finish_line = f;
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm, input int idx);
    chk({nm, " state"}, idx, race_state, 0);
    chk({nm, " digit"}, idx, countdown_digit, 0);
    chk({nm, " cur"},   idx, cur_lap_time, 0);
    chk({nm, " last"},  idx, last_lap_time, 0);
    chk({nm, " best"},  idx, best_lap_time, 0);
    chk({nm, " laps"},  idx, lap_count, 0);
    chk({nm, " done"},  idx, lap_done, 0);
  endtask

  // Behavioural model: time is tracked as pclk cycles since the last state
  // entry; centiseconds fall out by integer division.
  int m_state, m_age, m_cur, m_last, m_best, m_laps;
  bit m_armed, m_done, m_fin_prev, m_cp_prev;

  task automatic model_reset();
    m_state = 0; m_age = 0; m_cur = 0; m_last = 0; m_best = 0; m_laps = 0;
    m_armed = 0; m_done = 0; m_fin_prev = 0; m_cp_prev = 0;
  endtask

  task automatic model_step(input bit s, input bit c, input bit f);
    bit fr, cr, entered;
    fr = f && !m_fin_prev;
    cr = c && !m_cp_prev;
    entered = 0;
    m_done = 0;
    case (m_state)
      0, 3: if (s) begin
        m_state = 1; m_cur = 0; m_last = 0; m_best = 0; m_laps = 0; m_armed = 0;
        entered = 1;
      end
      1: if (m_age == C * T - 1) begin
        m_state = 2; m_cur = 0; entered = 1;
      end
      default: begin
        if (fr && m_armed) begin
`ifdef LAP_TIMER_BEST_LAP_EN
          if (m_laps == 0 || m_cur < m_best) m_best = m_cur;
`endif
          m_last = m_cur; m_cur = 0; m_laps++; m_done = 1;
          if (m_laps == NL) begin m_state = 3; entered = 1; end
        end else if ((m_age % T) == T - 1 && m_cur < 65535) begin
          m_cur++;
        end
        if (cr) m_armed = 1;
        else if (m_done) m_armed = 0;
      end
    endcase
    m_age = entered ? 0 : m_age + 1;
    m_fin_prev = f;
    m_cp_prev  = c;
  endtask

  initial begin
    // Directed table: each row is applied n cycles, checked after the last.
    tbl[0]  = mk(1, 0, 0,   1, 1, 3,  0,  0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,   4, 1, 3,  0,  0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,   4, 1, 2,  0,  0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,   4, 1, 2,  0,  0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,   4, 1, 1,  0,  0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0,   4, 1, 1,  0,  0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0,   3, 1, 1,  0,  0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0,   1, 2, 0,  0,  0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,  40, 2, 0, 10,  0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1,   1, 2, 0, 10,  0, 0, 0, 0);
    tbl[10] = mk(0, 0, 1,   3, 2, 0, 11,  0, 0, 0, 0);
    tbl[11] = mk(0, 1, 0,   1, 2, 0, 11,  0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 104, 2, 0, 37,  0, 0, 0, 0);
    tbl[13] = mk(0, 0, 1,   1, 2, 0,  0, 37, 1, 1, B1);
    tbl[14] = mk(0, 0, 0,   1, 2, 0,  0, 37, 1, 0, B1);
    tbl[15] = mk(0, 1, 0,   1, 2, 0,  1, 37, 1, 0, B1);
    tbl[16] = mk(0, 0, 0,  97, 2, 0, 25, 37, 1, 0, B1);
    tbl[17] = mk(0, 0, 1,   1, 3, 0,  0, 25, 2, 1, B2);
    tbl[18] = mk(0, 0, 0,   1, 3, 0,  0, 25, 2, 0, B2);
    tbl[19] = mk(0, 1, 0,   2, 3, 0,  0, 25, 2, 0, B2);
    tbl[20] = mk(0, 0, 1,   1, 3, 0,  0, 25, 2, 0, B2);
    tbl[21] = mk(1, 0, 0,   1, 1, 3,  0,  0, 0, 0, 0);
    tbl[22] = mk(0, 0, 0,   2, 1, 3,  0,  0, 0, 0, 0);

    rst = 1'b1; start = 0; checkpoint = 0; finish_line = 0;
    s_start = 0; s_cp = 0; s_fin = 0;
    repeat (2) @(posedge pclk);
    #1;
    chk_all_zero("reset", 0);
    rst = 1'b0;

    for (int i = 0; i <= 22; i++) begin
      for (int k = 0; k < tbl[i].n; k++) drive_cycle(tbl[i].st, tbl[i].cp, tbl[i].fin);
      chk("tbl state", i, race_state, tbl[i].e_state);
      chk("tbl digit", i, countdown_digit, tbl[i].e_digit);
      chk("tbl cur",   i, cur_lap_time, tbl[i].e_cur);
      chk("tbl last",  i, last_lap_time, tbl[i].e_last);
      chk("tbl laps",  i, lap_count, tbl[i].e_laps);
      chk("tbl done",  i, lap_done, tbl[i].e_done);
      chk("tbl best",  i, best_lap_time, tbl[i].e_best);
    end

    // Into RACING with a lap on the books, then reset between clock edges.
    repeat (22) drive_cycle(0, 0, 0);
    drive_cycle(0, 1, 0);
    repeat (20) drive_cycle(0, 0, 0);
    drive_cycle(0, 0, 1);
    drive_cycle(0, 0, 0);
    chk("pre-reset state", 0, race_state, 2);
    chk("pre-reset laps", 0, lap_count, 1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async reset", 0);
    @(posedge pclk);
    #1 rst = 1'b0;
    model_reset();

    for (int i = 0; i < 4000; i++) begin
      logic s, c, f;
      s = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 7) == 0);
      start = s; checkpoint = c; finish_line = f;
      @(posedge pclk);
      model_step(s, c, f);
      #1;
      chk("rnd state", i, race_state, m_state);
      chk("rnd digit", i, countdown_digit, (m_state == 1) ? 3 - (m_age / T) * 3 / C : 0);
      chk("rnd cur",   i, cur_lap_time, m_cur);
      chk("rnd last",  i, last_lap_time, m_last);
      chk("rnd best",  i, best_lap_time, m_best);
      chk("rnd laps",  i, lap_count, m_laps);
      chk("rnd done",  i, lap_done, m_done);
      if (i == 2000) begin
        start = 0; checkpoint = 0; finish_line = 0;
        #2 rst = 1'b1;
        #1;
        chk_all_zero("rnd reset", i);
        @(posedge pclk);
        #1 rst = 1'b0;
        model_reset();
      end
    end
    start = 0; checkpoint = 0; finish_line = 0;

    // Saturation on the one-tick-per-cycle instance.
    s_start = 1'b1;
    @(posedge pclk);
    #1 s_start = 1'b0;
    begin
      int budget;
      budget = 0;
      while (s_state != 2'd2 && budget < 50) begin
        @(posedge pclk);
        #1;
        budget++;
      end
    end
    chk("sat racing", 0, s_state, 2);
    repeat (65540) @(posedge pclk);
    #1;
    chk("sat cur", 0, s_cur, 16'hFFFF);
    repeat (10) @(posedge pclk);
    #1;
    chk("sat hold", 0, s_cur, 16'hFFFF);
    chk("sat digit", 0, s_digit, 0);
    s_cp = 1'b1;
    @(posedge pclk);
    #1 s_cp = 1'b0;
    @(posedge pclk);
    #1 s_fin = 1'b1;
    @(posedge pclk);
    #1;
    chk("sat last", 0, s_last, 16'hFFFF);
    chk("sat laps", 0, s_laps, 1);
    chk("sat done", 0, s_done, 1);
    chk("sat cur0", 0, s_cur, 0);
    chk("sat best", 0, s_best, BS);
    s_fin = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
